// File: rtl/gpmc_sync_target_pkg.sv
// ============================================================================
// gpmc_sync_target_pkg : shared types and constants for the GPMC sync target
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gpmc_sync_target_pkg;

    localparam int c_DEF_ADDR_W = 11;
    localparam int c_DEF_DATA_W = 16;

    // GPMC_WAIT is active-low; this is the "no wait" level.
    localparam logic c_WAIT_RELEASE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } gpmc_state_t;

endpackage

`default_nettype wire

// File: rtl/gpmc_addr_counter.sv
// ============================================================================
// gpmc_addr_counter : loadable, wrapping word-address counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpmc_addr_counter #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_load_val,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_addr_next
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_inc) begin
            r_addr <= o_addr_next;
        end
    end

    // Natural modulo-2^ADDR_W wrap from the top word back to zero.
    assign o_addr      = r_addr;
    assign o_addr_next = r_addr + ADDR_W'(1);

endmodule

`default_nettype wire

// File: rtl/gpmc_sync_target.sv
// ============================================================================
// gpmc_sync_target : synchronous muxed AD GPMC target driving a BRAM port
// Optional: GPMC_TARGET_WAIT_EN drives GPMC_WAIT low until first read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpmc_sync_target
    import gpmc_sync_target_pkg::*;
#(
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int RD_LATENCY = 2
) (
    input  logic              GPMC_CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] GPMC_AD_IN,
    output logic [DATA_W-1:0] GPMC_AD_OUT,
    output logic              GPMC_AD_OE,
    input  logic              GPMC_CS,
    input  logic              GPMC_ADV,
    input  logic              GPMC_OE,
    input  logic              GPMC_WE,
    input  logic              GPMC_BE0,
    input  logic              GPMC_BE1,
    output logic              GPMC_WAIT,
    output logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_din,
    input  logic [DATA_W-1:0] a_dout,
    output logic              a_ena,
    output logic              a_wr,
    output logic [1:0]        a_be
);

    localparam int                 c_LAT_W    = $clog2(RD_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(RD_LATENCY - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    gpmc_state_t       r_state;
    logic [c_LAT_W-1:0] r_lat;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_skid;
    logic              r_skid_vld;
    logic              w_load;
    logic              w_inc;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_addr_next;

    gpmc_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk         (GPMC_CLK),
        .rst_n       (RST_N),
        .i_load      (w_load),
        .i_inc       (w_inc),
        .i_load_val  (GPMC_AD_IN[ADDR_W-1:0]),
        .o_addr      (w_addr),
        .o_addr_next (w_addr_next)
    );

    // Reads: counter holds the last address issued to the RAM.
    // Writes: counter holds the address of the next data beat.
    always_comb begin
        w_load = ~GPMC_CS & ~GPMC_ADV;
        w_inc  = 1'b0;
        if (!GPMC_CS && GPMC_ADV) begin
            case (r_state)
                RD_WAIT: w_inc = (r_lat == c_LAT_ONE) || (r_lat == '0);
                RD_DATA: w_inc = ~GPMC_OE;
                WR_DATA: w_inc = ~GPMC_WE;
                default: w_inc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge GPMC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_lat      <= '0;
            r_dout     <= '0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
            a_ena      <= 1'b0;
            a_wr       <= 1'b0;
            a_be       <= 2'b00;
            a_addr     <= '0;
            a_din      <= '0;
        end else if (GPMC_CS) begin
            r_state    <= IDLE;
            r_skid_vld <= 1'b0;
            a_ena      <= 1'b0;
            a_wr       <= 1'b0;
        end else if (!GPMC_ADV) begin
            r_lat      <= c_LAT_INIT;
            r_skid_vld <= 1'b0;
            a_addr     <= GPMC_AD_IN[ADDR_W-1:0];
            a_wr       <= 1'b0;
            if (GPMC_WE) begin
                r_state <= RD_WAIT;
                a_ena   <= 1'b1;
            end else begin
                r_state <= WR_DATA;
                a_ena   <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    a_ena <= 1'b0;
                    a_wr  <= 1'b0;
                end
                RD_WAIT: begin
                    r_lat <= r_lat - c_LAT_ONE;
                    if ((r_lat == c_LAT_ONE) || (r_lat == '0)) begin
                        a_ena  <= 1'b1;
                        a_addr <= w_addr_next;
                    end
                    if (r_lat == '0) begin
                        r_dout  <= a_dout;
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (!GPMC_OE) begin
                        r_dout     <= r_skid_vld ? r_skid : a_dout;
                        r_skid_vld <= 1'b0;
                        a_ena      <= 1'b1;
                        a_addr     <= w_addr_next;
                    end else begin
                        // The read already in flight lands this edge, so park
                        // the word the host is owed before it is overwritten.
                        a_ena <= 1'b0;
                        if (!r_skid_vld) begin
                            r_skid     <= a_dout;
                            r_skid_vld <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (!GPMC_WE) begin
                        a_ena  <= 1'b1;
                        a_wr   <= 1'b1;
                        a_din  <= GPMC_AD_IN;
                        a_be   <= {~GPMC_BE1, ~GPMC_BE0};
                        a_addr <= w_addr;
                    end else begin
                        a_ena <= 1'b0;
                        a_wr  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GPMC_AD_OUT = r_dout;
    assign GPMC_AD_OE  = (r_state == RD_DATA) & ~GPMC_CS & ~GPMC_OE;

`ifdef GPMC_TARGET_WAIT_EN
    logic r_wait;

    always_ff @(posedge GPMC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait <= c_WAIT_RELEASE;
        end else if (GPMC_CS) begin
            r_wait <= c_WAIT_RELEASE;
        end else if (!GPMC_ADV) begin
            r_wait <= GPMC_WE ? ~c_WAIT_RELEASE : c_WAIT_RELEASE;
        end else if ((r_state == RD_WAIT) && (r_lat == '0)) begin
            r_wait <= c_WAIT_RELEASE;
        end
    end

    assign GPMC_WAIT = r_wait;
`else
    assign GPMC_WAIT = c_WAIT_RELEASE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpmc_sync_target.sv
// ============================================================================
// tb_gpmc_sync_target : directed + randomized bench with a word-level RAM model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpmc_sync_target;

`ifdef GPMC_TARGET_WAIT_EN
    localparam logic c_RD_WAIT_LVL = 1'b0;
`else
    localparam logic c_RD_WAIT_LVL = 1'b1;
`endif

    logic        GPMC_CLK;
    logic        RST_N;
    logic [15:0] GPMC_AD_IN;
    logic [15:0] GPMC_AD_OUT;
    logic        GPMC_AD_OE;
    logic        GPMC_CS;
    logic        GPMC_ADV;
    logic        GPMC_OE;
    logic        GPMC_WE;
    logic        GPMC_BE0;
    logic        GPMC_BE1;
    logic        GPMC_WAIT;
    logic [10:0] a_addr;
    logic [15:0] a_din;
    logic [15:0] a_dout;
    logic        a_ena;
    logic        a_wr;
    logic [1:0]  a_be;

    logic [15:0] mem     [0:2047];
    logic [15:0] ref_mem [0:2047];
    logic        ld_en;
    logic [10:0] ld_addr;
    logic [15:0] ld_data;

    int          n_chk;
    int          n_fail;
    logic [10:0] m_waddr;
    logic [10:0] ra;
    int          rn;

    gpmc_sync_target #(
        .ADDR_W     (11),
        .DATA_W     (16),
        .RD_LATENCY (2)
    ) dut (
        .GPMC_CLK    (GPMC_CLK),
        .RST_N       (RST_N),
        .GPMC_AD_IN  (GPMC_AD_IN),
        .GPMC_AD_OUT (GPMC_AD_OUT),
        .GPMC_AD_OE  (GPMC_AD_OE),
        .GPMC_CS     (GPMC_CS),
        .GPMC_ADV    (GPMC_ADV),
        .GPMC_OE     (GPMC_OE),
        .GPMC_WE     (GPMC_WE),
        .GPMC_BE0    (GPMC_BE0),
        .GPMC_BE1    (GPMC_BE1),
        .GPMC_WAIT   (GPMC_WAIT),
        .a_addr      (a_addr),
        .a_din       (a_din),
        .a_dout      (a_dout),
        .a_ena       (a_ena),
        .a_wr        (a_wr),
        .a_be        (a_be)
    );

    initial GPMC_CLK = 1'b0;
    always #5 GPMC_CLK = ~GPMC_CLK;

    // Block RAM: one-cycle registered read, output held while disabled.
    always @(posedge GPMC_CLK) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (a_ena) begin
            if (a_wr) begin
                if (a_be[0]) mem[a_addr][7:0]  <= a_din[7:0];
                if (a_be[1]) mem[a_addr][15:8] <= a_din[15:8];
            end else begin
                a_dout <= mem[a_addr];
            end
        end
    end

    task automatic tick();
        @(posedge GPMC_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input logic [10:0] a);
        chk("mem_word", {16'h0, mem[a]}, {16'h0, ref_mem[a]});
    endtask

    task automatic cyc_end();
        GPMC_CS  = 1'b1;
        GPMC_ADV = 1'b1;
        GPMC_OE  = 1'b1;
        GPMC_WE  = 1'b1;
        #1;
        chk("end_ad_oe_comb", GPMC_AD_OE, 1'b0);
        tick();
        chk("end_a_ena", a_ena, 1'b0);
        chk("end_wait", GPMC_WAIT, 1'b1);
        tick();
        chk("end_a_ena_hold", a_ena, 1'b0);
    endtask

    task automatic rd_cycle(input logic [10:0] a, input int n, input bit stalls, input bit finish);
        logic [15:0] last;
        GPMC_CS    = 1'b0;
        GPMC_ADV   = 1'b0;
        GPMC_WE    = 1'b1;
        GPMC_OE    = 1'b1;
        GPMC_AD_IN = {5'($urandom), a};
        tick();
        GPMC_ADV   = 1'b1;
        GPMC_AD_IN = 16'($urandom);
        chk("rd_wait_e0", GPMC_WAIT, c_RD_WAIT_LVL);
        chk("rd_ad_oe_e0", GPMC_AD_OE, 1'b0);
        tick();
        chk("rd_wait_e1", GPMC_WAIT, c_RD_WAIT_LVL);
        GPMC_OE = 1'b0;
        tick();
        last = ref_mem[a];
        chk("rd_first_word", GPMC_AD_OUT, last);
        chk("rd_first_ad_oe", GPMC_AD_OE, 1'b1);
        chk("rd_wait_e2", GPMC_WAIT, 1'b1);
        for (int k = 1; k < n; k++) begin
            if (stalls && ($urandom_range(0, 2) == 0)) begin
                GPMC_OE = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
                chk("rd_stall_ad_oe", GPMC_AD_OE, 1'b0);
                chk("rd_stall_hold", GPMC_AD_OUT, last);
                GPMC_OE = 1'b0;
            end
            tick();
            last = ref_mem[11'(a + 11'(k))];
            chk("rd_burst_word", GPMC_AD_OUT, last);
            chk("rd_burst_ad_oe", GPMC_AD_OE, 1'b1);
        end
        if (finish) cyc_end();
    endtask

    task automatic wr_start(input logic [10:0] a);
        GPMC_CS    = 1'b0;
        GPMC_ADV   = 1'b0;
        GPMC_WE    = 1'b0;
        GPMC_OE    = 1'b1;
        GPMC_AD_IN = {5'($urandom), a};
        tick();
        m_waddr = a;
        chk("wr_wait", GPMC_WAIT, 1'b1);
    endtask

    task automatic wr_beat(input logic [15:0] d, input logic [1:0] be_n);
        logic [1:0] be_exp;
        be_exp     = ~be_n;
        GPMC_ADV   = 1'b1;
        GPMC_WE    = 1'b0;
        GPMC_AD_IN = d;
        {GPMC_BE1, GPMC_BE0} = be_n;
        tick();
        chk("wr_a_wr", a_wr, 1'b1);
        chk("wr_a_ena", a_ena, 1'b1);
        chk("wr_a_addr", a_addr, m_waddr);
        chk("wr_a_be", a_be, be_exp);
        chk("wr_a_din", a_din, d);
        if (!be_n[0]) ref_mem[m_waddr][7:0]  = d[7:0];
        if (!be_n[1]) ref_mem[m_waddr][15:8] = d[15:8];
        m_waddr = m_waddr + 11'd1;
    endtask

    task automatic wr_gap();
        GPMC_ADV   = 1'b1;
        GPMC_WE    = 1'b1;
        GPMC_AD_IN = 16'($urandom);
        tick();
        chk("wr_gap_a_wr", a_wr, 1'b0);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        RST_N      = 1'b0;
        GPMC_CS    = 1'b1;
        GPMC_ADV   = 1'b1;
        GPMC_OE    = 1'b1;
        GPMC_WE    = 1'b1;
        GPMC_BE0   = 1'b1;
        GPMC_BE1   = 1'b1;
        GPMC_AD_IN = 16'h0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        tick();

        chk("rst_ad_out", GPMC_AD_OUT, 16'h0);
        chk("rst_ad_oe", GPMC_AD_OE, 1'b0);
        chk("rst_wait", GPMC_WAIT, 1'b1);
        chk("rst_a_ena", a_ena, 1'b0);
        chk("rst_a_wr", a_wr, 1'b0);
        chk("rst_a_be", a_be, 2'b00);
        chk("rst_a_addr", a_addr, 11'h0);
        chk("rst_a_din", a_din, 16'h0);

        // Preload RAM contents while the target is held in reset.
        ld_en = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            ld_addr = 11'(i);
            case (i)
                'h01F:   ld_data = 16'hBEEF;
                'h7FE:   ld_data = 16'h1111;
                'h7FF:   ld_data = 16'h2222;
                'h000:   ld_data = 16'h3333;
                'h001:   ld_data = 16'h4444;
                default: ld_data = 16'($urandom);
            endcase
            ref_mem[i] = ld_data;
            tick();
        end
        ld_en = 1'b0;
        RST_N = 1'b1;
        tick();

        rd_cycle(11'h01F, 1, 1'b0, 1'b1);
        rd_cycle(11'h7FE, 4, 1'b0, 1'b1);

        wr_start(11'h010);
        wr_beat(16'hA5A5, 2'b00);
        wr_beat(16'h5A5A, 2'b10);
        cyc_end();
        chk("wr_0x010_word", {16'h0, mem[11'h010]}, 32'hA5A5);
        chk("wr_0x011_low", {24'h0, mem[11'h011][7:0]}, 32'h5A);
        chk_mem(11'h011);

        // New E0 while a burst is in flight takes the new address.
        rd_cycle(11'h2A0, 3, 1'b0, 1'b0);
        rd_cycle(11'h055, 2, 1'b0, 1'b1);

        for (int it = 0; it < 24; it++) begin
            ra = 11'($urandom);
            rn = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 0) begin
                rd_cycle(ra, rn, 1'b1, 1'b1);
            end else begin
                wr_start(ra);
                for (int k = 0; k < rn; k++) begin
                    if ($urandom_range(0, 3) == 0) wr_gap();
                    wr_beat(16'($urandom), 2'($urandom));
                end
                cyc_end();
                for (int k = 0; k < rn; k++) chk_mem(11'(ra + 11'(k)));
            end
        end

        // Asynchronous reset with a write beat still pending in the RAM stage.
        wr_start(11'h100);
        wr_beat(16'hC3C3, 2'b00);
        wr_gap();
        GPMC_WE    = 1'b0;
        GPMC_AD_IN = 16'h7E7E;
        tick();
        RST_N = 1'b0;
        #1;
        chk("arst_ad_out", GPMC_AD_OUT, 16'h0);
        chk("arst_ad_oe", GPMC_AD_OE, 1'b0);
        chk("arst_wait", GPMC_WAIT, 1'b1);
        chk("arst_a_ena", a_ena, 1'b0);
        chk("arst_a_wr", a_wr, 1'b0);
        chk("arst_a_be", a_be, 2'b00);
        chk("arst_a_addr", a_addr, 11'h0);
        chk("arst_a_din", a_din, 16'h0);
        tick();
        RST_N   = 1'b1;
        GPMC_CS = 1'b1;
        GPMC_WE = 1'b1;
        tick();
        chk_mem(11'h100);
        chk_mem(11'h101);
        rd_cycle(11'h003, 1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
